// File: rtl/mbus_mem_responder.sv
// Memory-side mbus responder: fixed-latency single-outstanding reads, AW+W writes acked via a B FIFO.
// Define MBUS_RESP_STALL_EN to add LFSR-driven ar_ready/aw_ready backpressure.
module mbus_mem_responder #(
    parameter int                         MBUS_ADDR_WIDTH = 32,
    parameter int                         MBUS_DATA_WIDTH = 32,
    parameter int                         MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
    parameter int                         MEM_WORDS_BITS  = 10,
    parameter logic [MBUS_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                         RD_LAT          = 2,
    parameter int                         B_DEPTH_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr,
    input  logic                       mbus_ar_valid,
    output logic                       mbus_ar_ready,
    output logic [MBUS_DATA_WIDTH-1:0] mbus_r_data,
    output logic                       mbus_r_valid,
    input  logic                       mbus_r_ready,
    input  logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr,
    input  logic                       mbus_aw_valid,
    output logic                       mbus_aw_ready,
    input  logic [MBUS_DATA_WIDTH-1:0] mbus_w_data,
    input  logic                       mbus_w_valid,
    input  logic [MBUS_DW_B-1:0]       mbus_w_strb,
    output logic [1:0]                 mbus_b_resp,
    output logic                       mbus_b_valid,
    input  logic                       mbus_b_ready
);
    localparam int         BSHIFT    = $clog2(MBUS_DW_B);
    localparam int         MEM_WORDS = 1 << MEM_WORDS_BITS;
    localparam int         B_DEPTH   = 1 << B_DEPTH_BITS;
    localparam logic [3:0] LAT_M1    = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [MBUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Word index is taken after the wrapping subtract; anything beyond the RAM is out of range.
    function automatic logic [MBUS_ADDR_WIDTH-1:0] f_word(input logic [MBUS_ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> BSHIFT;
    endfunction

    logic [MBUS_ADDR_WIDTH-1:0] w_ar_word, w_aw_word;
    logic [MEM_WORDS_BITS-1:0]  w_ar_idx, w_aw_idx;
    logic                       w_ar_inrng, w_aw_inrng;

    assign w_ar_word  = f_word(mbus_ar_addr);
    assign w_aw_word  = f_word(mbus_aw_addr);
    assign w_ar_idx   = w_ar_word[MEM_WORDS_BITS-1:0];
    assign w_aw_idx   = w_aw_word[MEM_WORDS_BITS-1:0];
    assign w_ar_inrng = (mbus_ar_addr >= BASE_ADDR) && ((w_ar_word >> MEM_WORDS_BITS) == '0);
    assign w_aw_inrng = (mbus_aw_addr >= BASE_ADDR) && ((w_aw_word >> MEM_WORDS_BITS) == '0);

    logic w_ar_gate, w_aw_gate;
`ifdef MBUS_RESP_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_ar_gate = ~r_lfsr[1];
    assign w_aw_gate = ~r_lfsr[0];
`else
    assign w_ar_gate = 1'b1;
    assign w_aw_gate = 1'b1;
`endif

    // ---------------- read channel ----------------
    r_state_t                   r_state, w_state_nxt;
    logic [3:0]                 r_cnt, w_cnt_nxt;
    logic [MEM_WORDS_BITS-1:0]  r_idx, w_cap_idx;
    logic                       r_inrng, w_cap_rng;
    logic                       w_capture;
    logic [MBUS_DATA_WIDTH-1:0] r_rdata;
    logic                       w_ar_hs;

    assign mbus_ar_ready = rst_n && (r_state == R_IDLE) && w_ar_gate;
    assign w_ar_hs       = mbus_ar_valid && mbus_ar_ready;
    assign mbus_r_valid  = rst_n && (r_state == R_RESP);
    assign mbus_r_data   = rst_n ? r_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_cap_idx   = r_idx;
        w_cap_rng   = r_inrng;
        case (r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    if (RD_LAT == 1) begin
                        w_state_nxt = R_RESP;
                        w_capture   = 1'b1;
                        w_cap_idx   = w_ar_idx;
                        w_cap_rng   = w_ar_inrng;
                    end else begin
                        w_state_nxt = R_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            R_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = R_RESP;
                    w_capture   = 1'b1;
                end
            end
            R_RESP: begin
                if (mbus_r_ready) w_state_nxt = R_IDLE;
            end
            default: w_state_nxt = R_IDLE;
        endcase
    end

    // RAM is sampled with pre-edge contents, so a write landing on the capture edge is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_inrng <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ar_hs) begin
                r_idx   <= w_ar_idx;
                r_inrng <= w_ar_inrng;
            end
            if (w_capture) r_rdata <= w_cap_rng ? r_mem[w_cap_idx] : '0;
        end
    end

    // ---------------- write channel ----------------
    logic [1:0]              r_bq [B_DEPTH];
    logic [B_DEPTH_BITS-1:0] r_bwp, r_brp;
    logic [B_DEPTH_BITS:0]   r_bcnt;
    logic                    w_bfull, w_wr_acc, w_bpop;

    assign w_bfull       = (r_bcnt == (B_DEPTH_BITS + 1)'(B_DEPTH));
    assign mbus_aw_ready = rst_n && !w_bfull && w_aw_gate;
    assign w_wr_acc      = mbus_aw_valid && mbus_w_valid && mbus_aw_ready;
    assign mbus_b_valid  = rst_n && (r_bcnt != '0);
    assign mbus_b_resp   = mbus_b_valid ? r_bq[r_brp] : 2'b00;
    assign w_bpop        = mbus_b_valid && mbus_b_ready;

    always_ff @(posedge clk) begin
        if (w_wr_acc && w_aw_inrng) begin
            for (int b = 0; b < MBUS_DW_B; b++) begin
                if (mbus_w_strb[b]) r_mem[w_aw_idx][8*b +: 8] <= mbus_w_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bwp  <= '0;
            r_brp  <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_wr_acc) begin
                r_bq[r_bwp] <= w_aw_inrng ? 2'b00 : 2'b10;
                r_bwp       <= r_bwp + 1'b1;
            end
            if (w_bpop) r_brp <= r_brp + 1'b1;
            case ({w_wr_acc, w_bpop})
                2'b10:   r_bcnt <= r_bcnt + 1'b1;
                2'b01:   r_bcnt <= r_bcnt - 1'b1;
                default: r_bcnt <= r_bcnt;
            endcase
        end
    end
endmodule

// File: tb/tb_mbus_mem_responder.sv
// Bench for mbus_mem_responder: directed scenarios plus concurrent random read/write traffic
// checked against a transaction-level memory/response model.
module tb_mbus_mem_responder;
    localparam int     RD_LAT = 2;
    localparam longint BASE   = 0;
    localparam int     WORDS  = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mbus_ar_addr = '0;
    logic        mbus_ar_valid = 1'b0;
    logic        mbus_ar_ready;
    logic [31:0] mbus_r_data;
    logic        mbus_r_valid;
    logic        mbus_r_ready = 1'b0;
    logic [31:0] mbus_aw_addr = '0;
    logic        mbus_aw_valid = 1'b0;
    logic        mbus_aw_ready;
    logic [31:0] mbus_w_data = '0;
    logic        mbus_w_valid = 1'b0;
    logic [3:0]  mbus_w_strb = '0;
    logic [1:0]  mbus_b_resp;
    logic        mbus_b_valid;
    logic        mbus_b_ready = 1'b0;

    always #5 clk = ~clk;

    mbus_mem_responder #(.RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mbus_ar_addr(mbus_ar_addr), .mbus_ar_valid(mbus_ar_valid), .mbus_ar_ready(mbus_ar_ready),
        .mbus_r_data(mbus_r_data), .mbus_r_valid(mbus_r_valid), .mbus_r_ready(mbus_r_ready),
        .mbus_aw_addr(mbus_aw_addr), .mbus_aw_valid(mbus_aw_valid), .mbus_aw_ready(mbus_aw_ready),
        .mbus_w_data(mbus_w_data), .mbus_w_valid(mbus_w_valid), .mbus_w_strb(mbus_w_strb),
        .mbus_b_resp(mbus_b_resp), .mbus_b_valid(mbus_b_valid), .mbus_b_ready(mbus_b_ready)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mdl_mem [WORDS];
    logic [1:0]  bq [$];
    bit          wdone, rdone;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_inr(input logic [31:0] a);
        return (longint'(a) >= BASE) && ((longint'(a) - BASE) / 4 < WORDS);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_inr(a) ? mdl_mem[int'((longint'(a) - BASE) / 4)] : 32'h0;
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (mdl_inr(a)) begin
            int i = int'((longint'(a) - BASE) / 4);
            for (int b = 0; b < 4; b++) if (s[b]) mdl_mem[i][8*b +: 8] = d[8*b +: 8];
        end
        bq.push_back(mdl_inr(a) ? 2'b00 : 2'b10);
    endtask

    // Starts and ends just after a rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int t = 0;
        mbus_aw_addr = a; mbus_w_data = d; mbus_w_strb = s;
        mbus_aw_valid = 1'b1; mbus_w_valid = 1'b0;
        repeat (lead) begin @(posedge clk); #1; end
        mbus_w_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (mbus_aw_ready) break;
            if (++t > 200) begin
                chk("aw_timeout", 0, 1);
                @(posedge clk); #1;
                mbus_aw_valid = 1'b0; mbus_w_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        mbus_aw_valid = 1'b0; mbus_w_valid = 1'b0;
        mdl_wr(a, d, s);
    endtask

    // Expected data is the model state as of the edge that loads the response.
    task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] got);
        int          t = 0;
        int          lat = 0;
        logic [31:0] snap;
        got = '0;
        mbus_ar_addr = a; mbus_ar_valid = 1'b1; mbus_r_ready = 1'b0;
        forever begin
            @(negedge clk);
            snap = mdl_rd(a);
            if (mbus_ar_ready) break;
            if (++t > 200) begin
                chk("ar_timeout", 0, 1);
                mbus_ar_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        mbus_ar_valid = 1'b0; mbus_ar_addr = $urandom;
        forever begin
            @(negedge clk);
            lat++;
            if (mbus_r_valid) break;
            chk("ar_rdy_wait", mbus_ar_ready, 0);
            snap = mdl_rd(a);
            if (lat > 32) begin
                chk("r_timeout", 0, 1);
                @(posedge clk); #1;
                return;
            end
        end
        chk("r_lat", lat, RD_LAT);
        chk("r_data", mbus_r_data, snap);
        chk("ar_rdy_resp", mbus_ar_ready, 0);
        got = mbus_r_data;
        repeat (hold) begin
            @(negedge clk);
            chk("r_hold_data", mbus_r_data, got);
            chk("r_hold_vld", mbus_r_valid, 1);
            chk("ar_rdy_hold", mbus_ar_ready, 0);
        end
        mbus_r_ready = 1'b1;
        @(posedge clk); #1;
        mbus_r_ready = 1'b0;
        @(negedge clk);
        chk("ar_rdy_after_r", mbus_ar_ready, 1);
        chk("r_vld_drop", mbus_r_valid, 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_addr();
        int r = $urandom % 16;
        if (r < 8)  return ($urandom % 32) * 4 + ($urandom % 4);
        if (r < 15) return $urandom % (WORDS * 4);
        return 32'(WORDS * 4) + ($urandom % 4096);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mbus_b_valid && mbus_b_ready) begin
                if (bq.size() == 0) chk("b_extra", 1, 0);
                else                chk("b_resp", mbus_b_resp, bq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ar_rdy", mbus_ar_ready, 0);
        chk("rst_aw_rdy", mbus_aw_ready, 0);
        chk("rst_r_vld", mbus_r_valid, 0);
        chk("rst_b_vld", mbus_b_valid, 0);
        chk("rst_r_data", mbus_r_data, 0);
        chk("rst_b_resp", mbus_b_resp, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ar_rdy", mbus_ar_ready, 1);
        chk("post_rst_aw_rdy", mbus_aw_ready, 1);
        chk("post_rst_r_vld", mbus_r_valid, 0);
        chk("post_rst_b_vld", mbus_b_valid, 0);
        @(posedge clk); #1;

        // Preload every word so all later reads have defined expectations.
        mbus_b_ready = 1'b1;
        for (int i = 0; i < WORDS; i++) wr(32'(i * 4), $urandom, 4'hF, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Write then read back.
        wr(32'h40, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        chk("b_vld_next", mbus_b_valid, 1);
        chk("b_resp_ok", mbus_b_resp, 2'b00);
        @(posedge clk); #1;
        rd(32'h40, 0, got);
        chk("rd_deadbeef", got, 32'hDEADBEEF);

        // Partial strobe.
        wr(32'h10, 32'hFFFFFFFF, 4'hF, 0);
        wr(32'h10, 32'h00000000, 4'b0101, 0);
        rd(32'h10, 0, got);
        chk("pstrb", got, 32'hFF00FF00);

        // B FIFO full and single-pop recovery.
        repeat (3) begin @(posedge clk); #1; end
        mbus_b_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i * 4), $urandom, 4'hF, 0);
        @(negedge clk);
        chk("bfull_aw_rdy", mbus_aw_ready, 0);
        chk("bfull_b_vld", mbus_b_valid, 1);
        mbus_aw_addr = 32'h110; mbus_w_data = 32'h5A5A1234; mbus_w_strb = 4'hF;
        mbus_aw_valid = 1'b1; mbus_w_valid = 1'b1;
        repeat (2) begin @(negedge clk); chk("bfull_hold", mbus_aw_ready, 0); end
        @(posedge clk); #1;
        mbus_b_ready = 1'b1;
        @(negedge clk);
        chk("aw_rdy_pop_cyc", mbus_aw_ready, 0);
        @(posedge clk); #1;
        mbus_b_ready = 1'b0;
        @(negedge clk);
        chk("aw_rdy_after_pop", mbus_aw_ready, 1);
        @(posedge clk); #1;
        mbus_aw_valid = 1'b0; mbus_w_valid = 1'b0;
        mdl_wr(32'h110, 32'h5A5A1234, 4'hF);
        @(negedge clk);
        chk("bfull_again", mbus_aw_ready, 0);
        @(posedge clk); #1;
        mbus_b_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rd(32'h110, 0, got);
        chk("fifth_write", got, 32'h5A5A1234);

        // Out of range.
        wr(32'(WORDS * 4), 32'h12345678, 4'hF, 0);
        @(negedge clk);
        chk("oor_b_resp", mbus_b_resp, 2'b10);
        @(posedge clk); #1;
        rd(32'(WORDS * 4), 0, got);
        chk("oor_rdata", got, 0);
        rd(32'h0, 0, got);
        wr(32'hFFFFFFFC, 32'hCAFEF00D, 4'hF, 0);
        rd(32'hFFFFFFFC, 0, got);
        chk("oor_top_rdata", got, 0);

        // R backpressure.
        rd(32'h40, 5, got);
        chk("bp_data", got, 32'hDEADBEEF);

        // Reset while a read waits and two responses are queued.
        mbus_b_ready = 1'b0;
        wr(32'h80, 32'h0BADCAFE, 4'hF, 0);
        wr(32'h84, 32'h600DF00D, 4'hF, 0);
        mbus_ar_addr = 32'h40; mbus_ar_valid = 1'b1;
        @(negedge clk);
        chk("mid_ar_rdy", mbus_ar_ready, 1);
        @(posedge clk); #1;
        mbus_ar_valid = 1'b0;
        rst_n = 1'b0;
        bq.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_r_vld", mbus_r_valid, 0);
        chk("mid_rst_b_vld", mbus_b_valid, 0);
        chk("mid_rst_ar_rdy", mbus_ar_ready, 0);
        chk("mid_rst_aw_rdy", mbus_aw_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ar_rdy", mbus_ar_ready, 1);
        chk("rel_aw_rdy", mbus_aw_ready, 1);
        chk("rel_b_vld", mbus_b_valid, 0);
        chk("rel_r_vld", mbus_r_valid, 0);
        @(posedge clk); #1;
        mbus_b_ready = 1'b1;
        rd(32'h80, 0, got);
        chk("keep_80", got, 32'h0BADCAFE);
        rd(32'h40, 0, got);
        chk("keep_40", got, 32'hDEADBEEF);

        // Concurrent random traffic.
        wdone = 1'b0; rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    wr(pick_addr(), $urandom, 4'($urandom),
                       ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
                    repeat ($urandom % 3) begin @(posedge clk); #1; end
                end
                wdone = 1'b1;
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [31:0] rg;
                    rd(pick_addr(), int'($urandom % 4), rg);
                    repeat ($urandom % 3) begin @(posedge clk); #1; end
                end
                rdone = 1'b1;
            end
            begin
                while (!(wdone && rdone)) begin
                    @(posedge clk); #1;
                    mbus_b_ready = ($urandom % 4) != 0;
                end
            end
        join
        mbus_b_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("b_drain", bq.size(), 0);
        @(negedge clk);
        chk("b_idle", mbus_b_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
